// File: rtl/rx_dma_ctrl_flow_if.sv
// rtl/rx_dma_ctrl_flow_if.sv - signal bundle between one RX DMA flow controller and its RX buffer, descriptor FIFO and DMA engine
//
// Purpose: carries the run/interrupt control, the RX buffer length handshakes, the
// descriptor FIFO pop interface and the DMA engine request/completion interface.
// Ports (master = flow controller side):
//   run, interrupt                    software enable / page-filled pulse
//   buf_newlen(_dv), buf_rellen(_dv)  bytes written into / released from the RX buffer
//   desc_read, desc_do, desc_empty    show-ahead host page address FIFO
//   desc_enable                       lets the descriptor manager fill this flow
//   dma_addr, dma_dout, dma_req,      128-bit request readout and handshake
//   dma_ack, dma_done, dma_tag        acceptance and tagged completion
interface rx_dma_ctrl_flow_if #(
   parameter int DMA_DATA_WIDTH = 32
);
   localparam int NW = 128 / DMA_DATA_WIDTH;
   localparam int AW = (NW > 1) ? $clog2(NW) : 1;

   logic                      run;
   logic                      interrupt;
   logic [15:0]               buf_newlen;
   logic                      buf_newlen_dv;
   logic [15:0]               buf_rellen;
   logic                      buf_rellen_dv;
   logic                      desc_read;
   logic [63:0]               desc_do;
   logic                      desc_empty;
   logic                      desc_enable;
   logic [AW-1:0]             dma_addr;
   logic [DMA_DATA_WIDTH-1:0] dma_dout;
   logic                      dma_req;
   logic                      dma_ack;
   logic                      dma_done;
   logic [15:0]               dma_tag;

   modport master (
      input  run, buf_newlen, buf_newlen_dv, desc_do, desc_empty,
             dma_addr, dma_ack, dma_done, dma_tag,
      output interrupt, buf_rellen, buf_rellen_dv, desc_read, desc_enable,
             dma_dout, dma_req
   );

   modport slave (
      output run, buf_newlen, buf_newlen_dv, desc_do, desc_empty,
             dma_addr, dma_ack, dma_done, dma_tag,
      input  interrupt, buf_rellen, buf_rellen_dv, desc_read, desc_enable,
             dma_dout, dma_req
   );
endinterface

// File: rtl/rx_dma_ctrl_flow.sv
// rtl/rx_dma_ctrl_flow.sv - single-flow RX DMA request controller (RX buffer -> host memory)
//
// Purpose: counts bytes pending in the RX buffer, pulls host page addresses from the
// descriptor FIFO, issues one 128-bit DMA request at a time and releases buffer space
// when the DMA engine reports the matching tagged completion.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    rx_dma_ctrl_flow_if.master (buffer, descriptor and DMA engine signals)
// Request word layout: [15:0] len, [31:16] tag, [63:32] local buffer address, [127:64] host address.
module rx_dma_ctrl_flow #(
   parameter int          DMA_DATA_WIDTH = 32,
   parameter logic [31:0] BUFFER_ADDR    = 32'h0200_0000,
   parameter int          BUFFER_SIZE    = 4096,
   parameter int          MAX_XFER       = 512
) (
   input  logic               clk,
   input  logic               rst_n,
   rx_dma_ctrl_flow_if.master bus
);
   localparam int NW = 128 / DMA_DATA_WIDTH;
   localparam int OW = $clog2(BUFFER_SIZE);

   typedef enum logic [1:0] {IDLE, DESC, REQ, WAIT_DONE} state_t;

   state_t        state, state_n;
   logic [16:0]   pend;
   logic [OW-1:0] rd_off;
   logic [15:0]   tag;
   logic          desc_valid;
   logic [63:0]   host;
   logic [127:0]  req;
   logic          run_q;
   logic [15:0]   rellen;
   logic          rellen_dv;
   logic          irq;

   logic          desc_read;
   logic          take_desc;
   logic          latch_req;
   logic          done_ok;
   logic [15:0]   cur_len;
   logic [16:0]   room_page;
   logic [16:0]   room_buf;
   logic [16:0]   len_calc;
   logic [16:0]   pend_add;
   logic [16:0]   pend_sub;
   logic [63:0]   host_inc;

   // The in-flight length and tag live in the request registers themselves, so the
   // completion match and the release amount always agree with what the engine saw.
   assign cur_len  = req[15:0];
   assign done_ok  = (state == WAIT_DONE) && bus.dma_done && (bus.dma_tag == req[31:16]);
   assign host_inc = host + {48'd0, cur_len};

   // A transfer stops at the end of the host 4 KB page and at the buffer wrap point.
   assign room_page = 17'd4096 - {5'd0, host[11:0]};
   assign room_buf  = 17'(BUFFER_SIZE) - 17'(rd_off);

   always_comb begin
      len_calc = pend;
      if (len_calc > 17'(MAX_XFER)) len_calc = 17'(MAX_XFER);
      if (len_calc > room_page)     len_calc = room_page;
      if (len_calc > room_buf)      len_calc = room_buf;
   end

   assign pend_add = bus.buf_newlen_dv ? {1'b0, bus.buf_newlen} : 17'd0;
   assign pend_sub = done_ok ? {1'b0, cur_len} : 17'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      desc_read = 1'b0;
      take_desc = 1'b0;
      latch_req = 1'b0;
      case (state)
         IDLE: begin
            // RUN only gates starting new work; anything in flight finishes.
            if (bus.run && (pend != 17'd0)) begin
               if (desc_valid) begin
                  latch_req = 1'b1;
                  state_n   = REQ;
               end else begin
                  state_n   = DESC;
               end
            end
         end
         DESC: begin
            if (!bus.desc_empty) begin
               desc_read = 1'b1;
               take_desc = 1'b1;
               state_n   = IDLE;
            end
         end
         REQ: begin
            if (bus.dma_ack) state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_ok) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= '0;
         rd_off     <= '0;
         tag        <= '0;
         desc_valid <= 1'b0;
         host       <= '0;
         req        <= '0;
         run_q      <= 1'b0;
         rellen     <= '0;
         rellen_dv  <= 1'b0;
         irq        <= 1'b0;
      end else begin
         run_q     <= bus.run;
         pend      <= pend + pend_add - pend_sub;
         rellen_dv <= 1'b0;
         irq       <= 1'b0;
         if (take_desc) begin
            host       <= bus.desc_do;
            desc_valid <= 1'b1;
         end
         if (latch_req) begin
            req <= {host, BUFFER_ADDR + 32'(rd_off), tag, len_calc[15:0]};
         end
         if (done_ok) begin
            // rd_off is OW bits wide, so the add wraps modulo BUFFER_SIZE.
            rd_off    <= rd_off + cur_len[OW-1:0];
            host      <= host_inc;
            rellen    <= cur_len;
            rellen_dv <= 1'b1;
            tag       <= tag + 16'd1;
            if (host_inc[11:0] == 12'd0) begin
               desc_valid <= 1'b0;
               irq        <= 1'b1;
            end
         end
      end
   end

   // Zero-latency word readout of the request registers.
   logic [DMA_DATA_WIDTH-1:0] words [NW];
   for (genvar i = 0; i < NW; i++) begin : g_words
      assign words[i] = req[i*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
   end

   assign bus.dma_dout      = words[bus.dma_addr];
   assign bus.dma_req       = (state == REQ);
   assign bus.desc_read     = desc_read;
   assign bus.desc_enable   = run_q;
   assign bus.buf_rellen    = rellen;
   assign bus.buf_rellen_dv = rellen_dv;
   assign bus.interrupt     = irq;
endmodule

// File: tb/tb_rx_dma_ctrl_flow.sv
// tb/tb_rx_dma_ctrl_flow.sv - self-checking bench for rx_dma_ctrl_flow with a transfer-level reference model
module tb_rx_dma_ctrl_flow;
   localparam logic [31:0] BUF_ADDR = 32'h0200_0000;
   localparam int          BUF_SIZE = 4096;
   localparam int          MAXX     = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rx_dma_ctrl_flow_if #(.DMA_DATA_WIDTH(32)) ifc ();

   rx_dma_ctrl_flow #(
      .DMA_DATA_WIDTH(32), .BUFFER_ADDR(BUF_ADDR), .BUFFER_SIZE(BUF_SIZE), .MAX_XFER(MAXX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );

   int vecs = 0;
   int errs = 0;

   // Descriptor FIFO seen by the DUT (show-ahead).
   logic [63:0] desc_q[$];
   int          n_desc_reads = 0;

   always @(posedge clk) begin
      if (ifc.desc_read) begin
         void'(desc_q.pop_front());
         n_desc_reads++;
      end
      #1;
      ifc.desc_empty = (desc_q.size() == 0);
      ifc.desc_do    = (desc_q.size() != 0) ? desc_q[0] : 64'd0;
   end

   // Reference model: transfer-level bookkeeping from the byte-accounting rules.
   int          m_pend, m_off, m_tag, m_pops;
   logic [63:0] m_host;
   bit          m_valid;
   logic [63:0] m_desc[$];
   logic [127:0] last_r;
   logic         last_irq;

   task automatic push_desc(input logic [63:0] h);
      desc_q.push_back(h);
      m_desc.push_back(h);
   endtask

   task automatic predict(output int len, output int tg, output logic [31:0] loc,
                          output logic [63:0] hst);
      int pg, bf;
      if (!m_valid) begin
         m_host  = m_desc.pop_front();
         m_valid = 1;
         m_pops++;
      end
      pg  = 4096 - int'(m_host[11:0]);
      bf  = BUF_SIZE - m_off;
      len = m_pend;
      if (len > MAXX) len = MAXX;
      if (len > pg)   len = pg;
      if (len > bf)   len = bf;
      tg  = m_tag;
      loc = BUF_ADDR + 32'(m_off);
      hst = m_host;
   endtask

   task automatic retire(input int len, output bit page_end);
      m_pend  -= len;
      m_off    = (m_off + len) % BUF_SIZE;
      m_host   = m_host + 64'(len);
      m_tag    = (m_tag + 1) % 65536;
      page_end = (m_host[11:0] == 12'd0);
      if (page_end) m_valid = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ifc.run = 1'b0; ifc.buf_newlen = '0; ifc.buf_newlen_dv = 1'b0;
      ifc.dma_addr = '0; ifc.dma_ack = 1'b0; ifc.dma_done = 1'b0; ifc.dma_tag = '0;
      desc_q.delete(); m_desc.delete();
      m_pend = 0; m_off = 0; m_tag = 0; m_pops = 0; m_host = '0; m_valid = 0;
      n_desc_reads = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ifc.run = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive_newlen(input int n);
      ifc.buf_newlen_dv = 1'b1;
      ifc.buf_newlen    = 16'(n);
      @(negedge clk);
      ifc.buf_newlen_dv = 1'b0;
      m_pend += n;
   endtask

   // Acts as the DMA engine for one request; only collects observations.
   task automatic xfer(input int ack_dly, input logic [15:0] nl, output logic [127:0] r,
                       output logic [15:0] rel, output logic rdv, output logic irq,
                       output logic req_after_ack, output bit to);
      bit got = 0;
      r = '0; rel = '0; rdv = 0; irq = 0; req_after_ack = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         got = ifc.dma_req;
      end
      to = !got;
      if (to) return;
      for (int i = 0; i < 4; i++) begin
         ifc.dma_addr = 2'(i);
         #1;
         r[32*i +: 32] = ifc.dma_dout;
      end
      repeat (ack_dly) @(negedge clk);
      ifc.dma_ack = 1'b1;
      @(negedge clk);
      ifc.dma_ack   = 1'b0;
      req_after_ack = ifc.dma_req;
      ifc.dma_done  = 1'b1;
      ifc.dma_tag   = r[31:16];
      if (nl != 16'd0) begin
         ifc.buf_newlen_dv = 1'b1;
         ifc.buf_newlen    = nl;
      end
      @(negedge clk);
      ifc.dma_done      = 1'b0;
      ifc.buf_newlen_dv = 1'b0;
      rel = ifc.buf_rellen;
      rdv = ifc.buf_rellen_dv;
      irq = ifc.interrupt;
   endtask

   task automatic test_model_xfer(input string name, input int ack_dly, input int nl);
      int e_len, e_tag; logic [31:0] e_loc; logic [63:0] e_host; bit e_irq;
      logic [127:0] r; logic [15:0] rel; logic rdv, irq, rqa; bit to;
      predict(e_len, e_tag, e_loc, e_host);
      xfer(ack_dly, 16'(nl), r, rel, rdv, irq, rqa, to);
      last_r = r; last_irq = irq;
      vecs++;
      if (to) begin
         errs++;
         $display("FAIL %s timeout: no DMA_REQ within 300 cycles, expected len %0d", name, e_len);
         return;
      end
      retire(e_len, e_irq);
      m_pend += nl;
      vecs++; if (r[15:0] !== 16'(e_len)) begin errs++; $display("FAIL %s len: got %0d expected %0d", name, r[15:0], e_len); end
      vecs++; if (r[31:16] !== 16'(e_tag)) begin errs++; $display("FAIL %s tag: got %0d expected %0d", name, r[31:16], e_tag); end
      vecs++; if (r[63:32] !== e_loc) begin errs++; $display("FAIL %s local: got %h expected %h", name, r[63:32], e_loc); end
      vecs++; if (r[127:64] !== e_host) begin errs++; $display("FAIL %s host: got %h expected %h", name, r[127:64], e_host); end
      vecs++; if (rqa !== 1'b0) begin errs++; $display("FAIL %s req_drop: got %b expected 0", name, rqa); end
      vecs++; if ({rdv, rel} !== {1'b1, 16'(e_len)}) begin errs++; $display("FAIL %s rellen: got dv=%b %0d expected dv=1 %0d", name, rdv, rel, e_len); end
      vecs++; if (irq !== e_irq) begin errs++; $display("FAIL %s interrupt: got %b expected %b", name, irq, e_irq); end
      vecs++; if (n_desc_reads !== m_pops) begin errs++; $display("FAIL %s desc_reads: got %0d expected %0d", name, n_desc_reads, m_pops); end
   endtask

   task automatic test_reset();
      ifc.run = 1'b0; ifc.buf_newlen = '0; ifc.buf_newlen_dv = 1'b0;
      ifc.dma_addr = '0; ifc.dma_ack = 1'b0; ifc.dma_done = 1'b0; ifc.dma_tag = '0;
      repeat (2) @(negedge clk);
      vecs++;
      if ({ifc.dma_req, ifc.desc_read, ifc.desc_enable, ifc.buf_rellen_dv, ifc.interrupt, ifc.buf_rellen, ifc.dma_dout} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got req=%b rd=%b en=%b rdv=%b irq=%b rel=%h dout=%h expected all 0",
                  ifc.dma_req, ifc.desc_read, ifc.desc_enable, ifc.buf_rellen_dv, ifc.interrupt, ifc.buf_rellen, ifc.dma_dout);
      end
   endtask

   task automatic test_single();
      bit seen = 0;
      apply_reset();
      push_desc(64'h1_0000_0000);
      drive_newlen(100);
      test_model_xfer("single", 1, 0);
      vecs++; if (last_r !== {32'h1, 32'h0, 32'h0200_0000, 32'h0000_0064}) begin errs++; $display("FAIL single_words: got %h expected 00000001_00000000_02000000_00000064", last_r); end
      repeat (10) begin @(negedge clk); if (ifc.dma_req) seen = 1; end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL single_idle: got DMA_REQ=1 with PEND=0, expected 0"); end
   endtask

   task automatic test_split();
      apply_reset();
      push_desc(64'h1_0000_0000);
      drive_newlen(1200);
      for (int i = 0; i < 3; i++) begin
         test_model_xfer("split", i, 0);
         vecs++;
         if ({last_r[31:16], last_r[63:32]} !== {16'(i), BUF_ADDR + 32'(512*i)}) begin
            errs++; $display("FAIL split_%0d: got tag %0d local %h expected tag %0d local %h", i, last_r[31:16], last_r[63:32], i, BUF_ADDR + 32'(512*i));
         end
      end
      vecs++; if (last_r[15:0] !== 16'd176) begin errs++; $display("FAIL split_last_len: got %0d expected 176", last_r[15:0]); end
   endtask

   task automatic test_page();
      apply_reset();
      push_desc(64'h2_0000_0F00);
      push_desc(64'h3_0000_0000);
      drive_newlen(400);
      test_model_xfer("page1", 0, 0);
      vecs++; if ({last_r[15:0], last_irq} !== {16'd256, 1'b1}) begin errs++; $display("FAIL page_first: got len %0d irq %b expected 256 1", last_r[15:0], last_irq); end
      test_model_xfer("page2", 0, 0);
      vecs++; if ({last_r[127:64], last_r[15:0]} !== {64'h3_0000_0000, 16'd144}) begin errs++; $display("FAIL page_second: got host %h len %0d expected 300000000 144", last_r[127:64], last_r[15:0]); end
      vecs++; if (n_desc_reads !== 2) begin errs++; $display("FAIL page_desc_reads: got %0d expected 2", n_desc_reads); end
   endtask

   task automatic test_wrap();
      apply_reset();
      push_desc(64'h5_0000_0000);
      push_desc(64'h6_0000_0000);
      push_desc(64'h7_0000_0000);
      drive_newlen(4000);
      for (int n = 0; n < 20 && m_pend > 0; n++) test_model_xfer("wrap_fill", 0, 0);
      drive_newlen(200);
      test_model_xfer("wrap1", 0, 0);
      vecs++; if ({last_r[15:0], last_r[63:32]} !== {16'd96, 32'h0200_0FA0}) begin errs++; $display("FAIL wrap_first: got len %0d local %h expected 96 02000fa0", last_r[15:0], last_r[63:32]); end
      test_model_xfer("wrap2", 0, 0);
      vecs++; if ({last_r[15:0], last_r[63:32]} !== {16'd104, 32'h0200_0000}) begin errs++; $display("FAIL wrap_second: got len %0d local %h expected 104 02000000", last_r[15:0], last_r[63:32]); end
   endtask

   task automatic test_tag_and_simultaneous();
      int e_len, e_tag; logic [31:0] e_loc; logic [63:0] e_host; bit e_irq; bit got = 0; bit bad = 0;
      apply_reset();
      push_desc(64'h8_0000_0000);
      drive_newlen(300);
      predict(e_len, e_tag, e_loc, e_host);
      for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = ifc.dma_req; end
      vecs++; if (!got) begin errs++; $display("FAIL tag_req timeout: got no DMA_REQ expected one"); end
      ifc.dma_ack = 1'b1; @(negedge clk); ifc.dma_ack = 1'b0;
      ifc.dma_done = 1'b1; ifc.dma_tag = 16'(e_tag + 2);
      @(negedge clk);
      ifc.dma_done = 1'b0;
      vecs++; if (ifc.buf_rellen_dv !== 1'b0) begin errs++; $display("FAIL tag_wrong_release: got rellen_dv=%b expected 0", ifc.buf_rellen_dv); end
      repeat (4) begin @(negedge clk); if (ifc.dma_req || ifc.buf_rellen_dv) bad = 1; end
      vecs++; if (bad !== 1'b0) begin errs++; $display("FAIL tag_wrong_ignored: got activity=1 expected 0 (still waiting)"); end
      ifc.dma_done = 1'b1; ifc.dma_tag = 16'(e_tag);
      ifc.buf_newlen_dv = 1'b1; ifc.buf_newlen = 16'd64;
      @(negedge clk);
      ifc.dma_done = 1'b0; ifc.buf_newlen_dv = 1'b0;
      vecs++; if ({ifc.buf_rellen_dv, ifc.buf_rellen} !== {1'b1, 16'(e_len)}) begin errs++; $display("FAIL tag_match_release: got dv=%b %0d expected dv=1 %0d", ifc.buf_rellen_dv, ifc.buf_rellen, e_len); end
      retire(e_len, e_irq);
      m_pend += 64;
      test_model_xfer("simul", 0, 0);
      vecs++; if (last_r[15:0] !== 16'd64) begin errs++; $display("FAIL simul_len: got %0d expected 64", last_r[15:0]); end
   endtask

   task automatic test_reset_mid();
      bit got = 0;
      apply_reset();
      push_desc(64'hA_0000_0000);
      drive_newlen(600);
      test_model_xfer("rst_pre", 0, 0);
      for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = ifc.dma_req; end
      vecs++; if (!got) begin errs++; $display("FAIL rst_mid_req timeout: got no DMA_REQ expected one"); end
      ifc.dma_ack = 1'b1; @(negedge clk); ifc.dma_ack = 1'b0;
      ifc.dma_addr = 2'd0;
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if ({ifc.dma_req, ifc.desc_enable, ifc.buf_rellen_dv, ifc.interrupt, ifc.buf_rellen, ifc.dma_dout} !== '0) begin
         errs++;
         $display("FAIL rst_mid_outputs: got req=%b en=%b rdv=%b irq=%b rel=%h dout=%h expected all 0",
                  ifc.dma_req, ifc.desc_enable, ifc.buf_rellen_dv, ifc.interrupt, ifc.buf_rellen, ifc.dma_dout);
      end
      apply_reset();
      push_desc(64'hB_0000_0000);
      drive_newlen(50);
      test_model_xfer("rst_post", 0, 0);
      vecs++; if ({last_r[31:16], last_r[63:32]} !== {16'd0, BUF_ADDR}) begin errs++; $display("FAIL rst_post_start: got tag %0d local %h expected 0 %h", last_r[31:16], last_r[63:32], BUF_ADDR); end
   endtask

   task automatic test_run();
      bit seen = 0; bit got = 0;
      apply_reset();
      ifc.run = 1'b0;
      push_desc(64'h9_0000_0000);
      drive_newlen(100);
      repeat (20) begin @(negedge clk); if (ifc.dma_req || ifc.desc_read) seen = 1; end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL run_off_idle: got req/desc activity=1 expected 0"); end
      vecs++; if (ifc.desc_enable !== 1'b0) begin errs++; $display("FAIL run_off_enable: got %b expected 0", ifc.desc_enable); end
      ifc.run = 1'b1;
      @(negedge clk);
      vecs++; if (ifc.desc_enable !== 1'b1) begin errs++; $display("FAIL run_on_enable: got %b expected 1", ifc.desc_enable); end
      test_model_xfer("run_on", 0, 0);
      drive_newlen(1000);
      for (int n = 0; n < 100 && !got; n++) begin @(negedge clk); got = ifc.dma_req; end
      ifc.run = 1'b0;
      test_model_xfer("run_fall", 1, 0);
      seen = 0;
      repeat (20) begin @(negedge clk); if (ifc.dma_req) seen = 1; end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL run_fall_stop: got DMA_REQ=1 expected 0"); end
      ifc.run = 1'b1;
      for (int n = 0; n < 10 && m_pend > 0; n++) test_model_xfer("run_resume", 0, 0);
   endtask

   task automatic test_random();
      int nl;
      apply_reset();
      for (int it = 0; it < 40; it++) begin
         while (desc_q.size() < 2)
            push_desc({24'h0, 8'($urandom), 20'($urandom), 12'($urandom_range(0, 4095))});
         if (m_pend == 0) drive_newlen($urandom_range(1, BUF_SIZE));
         nl = 0;
         if (($urandom % 3) == 0 && m_pend < BUF_SIZE) nl = $urandom_range(1, BUF_SIZE - m_pend);
         test_model_xfer("random", $urandom_range(0, 3), nl);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_page();
      test_wrap();
      test_tag_and_simultaneous();
      test_reset_mid();
      test_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/rx_dma_ctrl_flow.md
Name: rx_dma_ctrl_flow

Overview:
Single-flow RX DMA request controller, the FPGA-to-host counterpart of the TX DMA controller. It tracks bytes the RX buffer announces as written and pulls 64-bit host page addresses from the descriptor FIFO. It issues 128-bit DMA requests that move buffer data to host memory, and releases buffer space once the DMA engine reports completion. One instance per flow sits between the RX buffer, the descriptor manager and the DMA engine.

Parameters:
DMA_DATA_WIDTH, 32, width of DMA request read port; 128 must be divisible by it; AW = log2(128/DMA_DATA_WIDTH).
BUFFER_ADDR, 32'h0200_0000, internal-bus base address of this flow's RX buffer.
BUFFER_SIZE, 4096, RX buffer bytes, power of two; OW = log2(BUFFER_SIZE).
MAX_XFER, 512, maximum bytes per DMA request, power of two, no larger than 4096.

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
RUN  in  1  software enable for this flow
INTERRUPT  out  1  one-cycle pulse when a descriptor page is completely filled
BUF_NEWLEN  in  16  bytes newly written into the RX buffer
BUF_NEWLEN_DV  in  1  BUF_NEWLEN valid
BUF_RELLEN  out  16  bytes released back to the RX buffer
BUF_RELLEN_DV  out  1  BUF_RELLEN valid, one-cycle pulse
DESC_READ  out  1  pop descriptor FIFO
DESC_DO  in  64  descriptor: host address, show-ahead
DESC_EMPTY  in  1  descriptor FIFO empty
DESC_ENABLE  out  1  permits the descriptor manager to fill this flow; equals registered RUN
DMA_ADDR  in  AW  word index into the current request
DMA_DOUT  out  DMA_DATA_WIDTH  selected request word
DMA_REQ  out  1  request pending
DMA_ACK  in  1  request accepted, one cycle
DMA_DONE  in  1  transfer completed
DMA_TAG  in  16  tag of the completed transfer

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0; FSM enters IDLE; PEND, rd_off, tag, desc_valid, request registers and host address all cleared.
- PEND (17 b): pending bytes. Updated as PEND + (NEWLEN_DV ? NEWLEN : 0) - (done ? len : 0), so a NEWLEN and a DONE in the same cycle both apply.
  - Upstream never announces more than BUFFER_SIZE outstanding.
- Request layout (128 b): [15:0] len, [31:16] tag, [63:32] BUFFER_ADDR + rd_off, [127:64] host address.
  - DMA_DOUT = word DMA_ADDR of the request registers, combinational, zero latency.
  - Request registers are stable from DMA_REQ rise until the next transfer completes.
- FSM, one state per cycle minimum:
  - IDLE
    - If RUN=1, PEND>0 and desc_valid=0: go to DESC.
    - If RUN=1, PEND>0 and desc_valid=1: len = min(PEND, MAX_XFER, 4096 - host[11:0], BUFFER_SIZE - rd_off). Latch the request, go to REQ.
    - A transfer never crosses a host 4 KB page or the buffer wrap point.
  - DESC
    - If DESC_EMPTY=0: DESC_READ=1 for one cycle; latch DESC_DO into host; desc_valid=1; go to IDLE.
    - Otherwise wait.
  - REQ: DMA_REQ=1 until DMA_ACK is sampled high; on ACK, DMA_REQ drops the next cycle and the FSM goes to WAIT_DONE.
  - WAIT_DONE
    - Wait for DMA_DONE=1 with DMA_TAG == tag. A DONE with a different tag is ignored.
    - On a matching DONE:
      - rd_off = (rd_off + len) mod BUFFER_SIZE.
      - host += len.
      - BUF_RELLEN = len with BUF_RELLEN_DV pulse.
      - tag = tag + 1, wrapping at 16 bits.
      - If the new host[11:0] == 0: desc_valid=0 and INTERRUPT pulses, in the same cycle as BUF_RELLEN_DV.
      - Go to IDLE.
- RUN falling: an outstanding REQ or WAIT_DONE completes normally; no new DESC or REQ is started; desc_valid is kept.
- Throughput: one transfer outstanding at a time. From PEND>0 in IDLE with desc_valid=1, DMA_REQ rises on the next cycle.

Test Plan:
1. Single transfer. Setup: RUN=1, DESC_DO=64'h1_0000_0000, NEWLEN=100. Then DMA_ACK, then DONE with tag 0.
   -> one DESC_READ pulse; words 0..3 = 32'h0000_0064, 32'h0200_0000, 32'h0, 32'h1; RELLEN=100 with DV; PEND=0.
2. MAX_XFER split: NEWLEN=1200 -> three requests with len 512, 512, 176; tags 0, 1, 2; local offsets 0, 512, 1024.
3. Page boundary: host=0x...0F00, NEWLEN=400.
   -> first len 256; INTERRUPT and RELLEN=256 in the same cycle; second DESC_READ; then len 144 at the new host address.
4. Buffer wrap: rd_off=4000, PEND=200 -> len 96 at local 0x0200_0FA0, then len 104 at local 0x0200_0000.
5. Tag and simultaneous events: DONE with tag 5 while expecting tag 3 -> ignored, FSM stays in WAIT_DONE. A correct DONE in the same cycle as NEWLEN=64 -> PEND = old + 64 - len.
6. Reset and RUN control:
   - RESET low during WAIT_DONE -> all outputs 0 immediately; after release, tag=0 and a new request starts at local offset 0.
   - RUN=0 with PEND>0 -> no DMA_REQ.
